snp_req_issuer: RTL and testbench

Initiating side of the snoop protocol. It accepts one coherence request at a time from the local cache controller (read miss, write miss, or write-upgrade on a SHARED line) and broadcasts the matching snoop operation (`SNP_RD`, `SNP_RWITM`, `SNP_INV`) to all peer caches. It then collects peer snoop responses over a fixed window and returns the MESI state the local line must be filled or upgraded to. It sits between the local cache FSM and the snoop bus that feeds every peer's snoop-request controller.

---
 rtl/snp_req_issuer.sv | 190 +++++++++++++++++++
 tb/tb_snp_req_issuer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/snp_req_issuer.sv
// Snoop request issuer: turns one local coherence request into a broadcast snoop,
// gathers peer responses over a fixed window and reports the resulting MESI fill state.
module snp_req_issuer #(
   parameter int NUM_PEERS = 3,
   parameter int ADDR_W    = 32,
   parameter int RSP_WAIT  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   input  logic [1:0]             req_op,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   req_ready,
   output logic [2:0]             snp_op,
   output logic [ADDR_W-1:0]      snp_addr,
   input  logic [2*NUM_PEERS-1:0] snp_rsp,
   output logic                   done,
   output logic [2:0]             fill_st,
   output logic                   peer_hit
);

   localparam logic [2:0] SNP_NO_REQ = 3'd0;
   localparam logic [2:0] SNP_RD     = 3'd1;
   localparam logic [2:0] SNP_RWITM  = 3'd2;
   localparam logic [2:0] SNP_INV    = 3'd3;

   localparam logic [1:0] SNP_NO_RSP = 2'd0;
   localparam logic [1:0] SNP_FOUND  = 2'd1;

   localparam logic [2:0] ST_INVALID   = 3'd0;
   localparam logic [2:0] ST_SHARED    = 3'd1;
   localparam logic [2:0] ST_EXCLUSIVE = 3'd2;
   localparam logic [2:0] ST_MODIFIED  = 3'd3;

   localparam logic [1:0] OP_RD_MISS  = 2'd0;
   localparam logic [1:0] OP_WR_MISS  = 2'd1;
   localparam logic [1:0] OP_UPGRADE  = 2'd2;
   localparam logic [1:0] OP_RESERVED = 2'd3;

   localparam logic [3:0] CNT_LOAD = (RSP_WAIT > 0) ? 4'(RSP_WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Anything other than SNP_FOUND from a peer is treated as a miss.
   function automatic logic any_found(input logic [2*NUM_PEERS-1:0] rsp);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_PEERS; i++) begin
         if (rsp[2*i +: 2] == SNP_FOUND) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

   function automatic logic [2:0] op_to_snp(input logic [1:0] op);
      logic [2:0] code;
      case (op)
         OP_RD_MISS: code = SNP_RD;
         OP_WR_MISS: code = SNP_RWITM;
         OP_UPGRADE: code = SNP_INV;
         default:    code = SNP_NO_REQ;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] fill_of(input logic [1:0] op, input logic hit);
      logic [2:0] st;
      case (op)
         OP_RD_MISS: st = hit ? ST_SHARED : ST_EXCLUSIVE;
         OP_WR_MISS: st = ST_MODIFIED;
         OP_UPGRADE: st = ST_MODIFIED;
         default:    st = ST_INVALID;
      endcase
      return st;
   endfunction

   state_t              state_r, state_nxt_s;
   logic [1:0]          op_r, op_nxt_s;
   logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
   logic [3:0]          cnt_r, cnt_nxt_s;
   logic                acc_r, acc_nxt_s;
   logic [2:0]          snp_op_r, snp_op_nxt_s;
   logic [ADDR_W-1:0]   snp_addr_r, snp_addr_nxt_s;
   logic                done_r, done_nxt_s;
   logic [2:0]          fill_st_r, fill_st_nxt_s;
   logic                peer_hit_r, peer_hit_nxt_s;
   logic                hit_now_s;

   assign hit_now_s = any_found(snp_rsp);

   // Next-state logic; registered outputs are computed for the state being entered.
   always_comb begin
      state_nxt_s    = state_r;
      op_nxt_s       = op_r;
      addr_nxt_s     = addr_r;
      cnt_nxt_s      = cnt_r;
      acc_nxt_s      = acc_r;
      snp_op_nxt_s   = SNP_NO_REQ;
      snp_addr_nxt_s = {ADDR_W{1'b0}};
      done_nxt_s     = 1'b0;
      fill_st_nxt_s  = ST_INVALID;
      peer_hit_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid && (req_op != OP_RESERVED)) begin
               op_nxt_s       = req_op;
               addr_nxt_s     = req_addr;
               snp_op_nxt_s   = op_to_snp(req_op);
               snp_addr_nxt_s = req_addr;
               state_nxt_s    = ISSUE;
            end else begin
               state_nxt_s    = IDLE;
            end
         end
         ISSUE: begin
            acc_nxt_s = hit_now_s;
            if (RSP_WAIT > 0) begin
               cnt_nxt_s   = CNT_LOAD;
               state_nxt_s = WAIT;
            end else begin
               done_nxt_s     = 1'b1;
               fill_st_nxt_s  = fill_of(op_r, hit_now_s);
               peer_hit_nxt_s = hit_now_s;
               state_nxt_s    = DONE;
            end
         end
         WAIT: begin
            acc_nxt_s = acc_r | hit_now_s;
            if (cnt_r == 4'd0) begin
               done_nxt_s     = 1'b1;
               fill_st_nxt_s  = fill_of(op_r, acc_r | hit_now_s);
               peer_hit_nxt_s = acc_r | hit_now_s;
               state_nxt_s    = DONE;
            end else begin
               cnt_nxt_s   = cnt_r - 4'd1;
               state_nxt_s = WAIT;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         op_r       <= OP_RD_MISS;
         addr_r     <= {ADDR_W{1'b0}};
         cnt_r      <= 4'd0;
         acc_r      <= 1'b0;
         snp_op_r   <= SNP_NO_REQ;
         snp_addr_r <= {ADDR_W{1'b0}};
         done_r     <= 1'b0;
         fill_st_r  <= ST_INVALID;
         peer_hit_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         op_r       <= op_nxt_s;
         addr_r     <= addr_nxt_s;
         cnt_r      <= cnt_nxt_s;
         acc_r      <= acc_nxt_s;
         snp_op_r   <= snp_op_nxt_s;
         snp_addr_r <= snp_addr_nxt_s;
         done_r     <= done_nxt_s;
         fill_st_r  <= fill_st_nxt_s;
         peer_hit_r <= peer_hit_nxt_s;
      end
   end

   assign req_ready = (state_r == IDLE);
   assign snp_op    = snp_op_r;
   assign snp_addr  = snp_addr_r;
   assign done      = done_r;
   assign fill_st   = fill_st_r;
   assign peer_hit  = peer_hit_r;

endmodule

// File: tb/tb_snp_req_issuer.sv
// Bench for snp_req_issuer: table-driven requests on a RSP_WAIT=2 instance with a
// completion scoreboard, plus hand sequences for reset abort and RSP_WAIT=0 back-to-back.
module tb_snp_req_issuer;

   localparam logic [2:0] NO_REQ = 3'd0, RD = 3'd1, RWITM = 3'd2, INV = 3'd3;
   localparam logic [2:0] S_I = 3'd0, S_S = 3'd1, S_E = 3'd2, S_M = 3'd3;
   localparam logic [1:0] FOUND = 2'd1;
   localparam int W = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        req_valid_a, req_ready_a, done_a, peer_hit_a;
   logic [1:0]  req_op_a;
   logic [31:0] req_addr_a, snp_addr_a;
   logic [2:0]  snp_op_a, fill_st_a;
   logic [5:0]  snp_rsp_a;

   logic        req_valid_b, req_ready_b, done_b, peer_hit_b;
   logic [1:0]  req_op_b;
   logic [15:0] req_addr_b, snp_addr_b;
   logic [2:0]  snp_op_b, fill_st_b;
   logic [3:0]  snp_rsp_b;

   snp_req_issuer #(.NUM_PEERS(3), .ADDR_W(32), .RSP_WAIT(W)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_op(req_op_a),
      .req_addr(req_addr_a), .req_ready(req_ready_a), .snp_op(snp_op_a),
      .snp_addr(snp_addr_a), .snp_rsp(snp_rsp_a), .done(done_a),
      .fill_st(fill_st_a), .peer_hit(peer_hit_a));

   snp_req_issuer #(.NUM_PEERS(2), .ADDR_W(16), .RSP_WAIT(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_op(req_op_b),
      .req_addr(req_addr_b), .req_ready(req_ready_b), .snp_op(snp_op_b),
      .snp_addr(snp_addr_b), .snp_rsp(snp_rsp_b), .done(done_b),
      .fill_st(fill_st_b), .peer_hit(peer_hit_b));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      int          hcyc;   // cycle relative to ISSUE carrying the response, -1 = none
      int          hpeer;
      logic [1:0]  hval;
      logic [2:0]  esnp;
      logic [2:0]  efill;
      logic        ehit;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr, input int hcyc,
                               input int hpeer, input logic [1:0] hval, input logic [2:0] esnp,
                               input logic [2:0] efill, input logic ehit);
      vec_t v;
      v.op = op; v.addr = addr; v.hcyc = hcyc; v.hpeer = hpeer; v.hval = hval;
      v.esnp = esnp; v.efill = efill; v.ehit = ehit;
      return v;
   endfunction

   logic [3:0] q_a[$];
   logic [3:0] q_b[$];

   // Completion scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done_a) begin
            if (q_a.size() == 0) chk("unexpected_done_a", 32'd1, 32'd0);
            else begin
               logic [3:0] e;
               e = q_a.pop_front();
               chk("fill_st_a", 32'(fill_st_a), 32'(e[3:1]));
               chk("peer_hit_a", 32'(peer_hit_a), 32'(e[0]));
            end
         end else begin
            chk("idle_result_a", {28'd0, fill_st_a, peer_hit_a}, {28'd0, S_I, 1'b0});
         end
         if (done_b) begin
            if (q_b.size() == 0) chk("unexpected_done_b", 32'd1, 32'd0);
            else begin
               logic [3:0] e;
               e = q_b.pop_front();
               chk("fill_st_b", 32'(fill_st_b), 32'(e[3:1]));
               chk("peer_hit_b", 32'(peer_hit_b), 32'(e[0]));
            end
         end else begin
            chk("idle_result_b", {28'd0, fill_st_b, peer_hit_b}, {28'd0, S_I, 1'b0});
         end
      end
   end

   task automatic run_req(input vec_t v);
      @(negedge clk);
      chk("ready_in_idle", 32'(req_ready_a), 32'd1);
      req_valid_a = 1'b1; req_op_a = v.op; req_addr_a = v.addr;
      q_a.push_back({v.efill, v.ehit});
      for (int c = 0; c <= W + 2; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req_valid_a = 1'b0; req_op_a = 2'd1; req_addr_a = ~v.addr;
         end
         snp_rsp_a = (c == v.hcyc) ? (6'(v.hval) << (2 * v.hpeer)) : 6'd0;
         @(negedge clk);
         if (c == 0) begin
            chk("snp_op_issue", 32'(snp_op_a), 32'(v.esnp));
            chk("snp_addr_issue", snp_addr_a, v.addr);
            chk("ready_busy", 32'(req_ready_a), 32'd0);
         end else begin
            chk("snp_op_quiet", 32'(snp_op_a), 32'(NO_REQ));
         end
         chk("done_timing", 32'(done_a), (c == W + 1) ? 32'd1 : 32'd0);
      end
      snp_rsp_a = 6'd0;
   endtask

   vec_t vecs[10];

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = mk(2'd0, 32'h0000_1000, -1, 0, FOUND,  RD,    S_E, 1'b0);
      vecs[1] = mk(2'd0, 32'h0000_2040,  2, 2, FOUND,  RD,    S_S, 1'b1);
      vecs[2] = mk(2'd0, 32'h0000_3080,  3, 2, FOUND,  RD,    S_E, 1'b0);
      vecs[3] = mk(2'd0, 32'h0000_30C0,  4, 2, FOUND,  RD,    S_E, 1'b0);
      vecs[4] = mk(2'd1, 32'hDEAD_BEC0,  0, 0, FOUND,  RWITM, S_M, 1'b1);
      vecs[5] = mk(2'd2, 32'h1234_5600, -1, 0, FOUND,  INV,   S_M, 1'b0);
      vecs[6] = mk(2'd0, 32'h0BAD_F000,  1, 1, 2'd3,   RD,    S_E, 1'b0);
      vecs[7] = mk(2'd0, 32'hFFFF_FFC0,  0, 0, FOUND,  RD,    S_S, 1'b1);
      vecs[8] = mk(2'd2, 32'h0000_0040,  1, 1, FOUND,  INV,   S_M, 1'b1);
      vecs[9] = mk(2'd1, 32'h8000_0000, -1, 0, FOUND,  RWITM, S_M, 1'b0);

      rst_n = 1'b0;
      req_valid_a = 1'b0; req_op_a = 2'd0; req_addr_a = 32'd0; snp_rsp_a = 6'd0;
      req_valid_b = 1'b0; req_op_b = 2'd0; req_addr_b = 16'd0; snp_rsp_b = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready_a), 32'd1);
      chk("rst_snp_op", 32'(snp_op_a), 32'(NO_REQ));
      chk("rst_snp_addr", snp_addr_a, 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_fill", 32'(fill_st_a), 32'(S_I));
      chk("rst_hit", 32'(peer_hit_a), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_req(vecs[i]);

      // Reserved op must not be accepted.
      @(negedge clk);
      req_valid_a = 1'b1; req_op_a = 2'd3; req_addr_a = 32'h0000_5500;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rsvd_ready", 32'(req_ready_a), 32'd1);
         chk("rsvd_snp_op", 32'(snp_op_a), 32'(NO_REQ));
         chk("rsvd_done", 32'(done_a), 32'd0);
      end
      req_valid_a = 1'b0; req_op_a = 2'd0;

      // Reset during WAIT aborts the request without a done pulse.
      @(negedge clk);
      req_valid_a = 1'b1; req_op_a = 2'd0; req_addr_a = 32'h0000_7700;
      @(posedge clk); #1;
      req_valid_a = 1'b0; snp_rsp_a = 6'b000001;
      @(posedge clk); #1;
      snp_rsp_a = 6'd0; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 32'(req_ready_a), 32'd1);
      chk("abort_snp_op", 32'(snp_op_a), 32'(NO_REQ));
      chk("abort_snp_addr", snp_addr_a, 32'd0);
      chk("abort_done", 32'(done_a), 32'd0);
      chk("abort_fill", 32'(fill_st_a), 32'(S_I));
      chk("abort_hit", 32'(peer_hit_a), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done_a), 32'd0);
      end
      run_req(vecs[0]);

      // RSP_WAIT=0, two back-to-back read misses with valid held high.
      @(negedge clk);
      chk("b_ready_idle", 32'(req_ready_b), 32'd1);
      req_valid_b = 1'b1; req_op_b = 2'd0; req_addr_b = 16'h00A1;
      q_b.push_back({S_S, 1'b1});
      q_b.push_back({S_E, 1'b0});
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         snp_rsp_b = (k == 1) ? 4'b0001 : 4'b0000;
         if (k == 1) req_addr_b = 16'h00B2;
         if (k == 5) req_valid_b = 1'b0;
         @(negedge clk);
         chk("b_done_timing", 32'(done_b), (k == 2 || k == 5) ? 32'd1 : 32'd0);
         if (k == 1 || k == 4) begin
            chk("b_snp_op", 32'(snp_op_b), 32'(RD));
            chk("b_snp_addr", 32'(snp_addr_b), (k == 1) ? 32'h00A1 : 32'h00B2);
         end else begin
            chk("b_snp_quiet", 32'(snp_op_b), 32'(NO_REQ));
         end
         if (k == 3) chk("b_ready_gap", 32'(req_ready_b), 32'd1);
      end

      repeat (2) @(negedge clk);
      chk("q_a_drained", 32'(q_a.size()), 32'd0);
      chk("q_b_drained", 32'(q_b.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
